slot_reel_controller: RTL and testbench

//  Game sequencer for the three-reel slot machine. Spins three reel symbol counters, stops them one at a time on player stop presses, and scores the result.

---
 rtl/slot_pkg.sv | 64 ++++++
 rtl/slot_tick_gen.sv | 31 +++
 rtl/slot_reel_controller.sv | 239 +++++++++++++++++++++++
 tb/tb_slot_reel_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// Shared definitions for the three-reel slot machine: FSM encoding,
// reel strides, credit width and small arithmetic helpers.
package slot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPIN3 = 3'd1,
        ST_SPIN2 = 3'd2,
        ST_SPIN1 = 3'd3,
        ST_EVAL  = 3'd4,
        ST_SHOW  = 3'd5
    } state_t;

    // Per-reel step sizes; all are coprime to 9 so every symbol is reachable.
    localparam logic [3:0] STRIDE0 = 4'd1;
    localparam logic [3:0] STRIDE1 = 4'd2;
    localparam logic [3:0] STRIDE2 = 4'd4;

    localparam int CRED_W = 7;

    // Advance a reel by its stride and wrap with a single compare/subtract.
    function automatic logic [3:0] reel_step(input logic [3:0] cur,
                                             input logic [3:0] stride,
                                             input logic [3:0] num_sym);
        logic [3:0] sum;
        sum = cur + stride;
        if (sum >= num_sym) begin
            return sum - num_sym;
        end else begin
            return sum;
        end
    endfunction

    // Credit add that clamps at the display ceiling.
    function automatic logic [CRED_W-1:0] cred_sat_add(input logic [CRED_W-1:0] cur,
                                                       input logic [CRED_W-1:0] add,
                                                       input logic [CRED_W-1:0] ceil);
        logic [CRED_W:0] sum;
        sum = {1'b0, cur} + {1'b0, add};
        if (sum > {1'b0, ceil}) begin
            return ceil;
        end else begin
            return sum[CRED_W-1:0];
        end
    endfunction

    // Split a 0..99 binary value into {tens, ones} BCD digits.
    function automatic logic [7:0] bcd_split(input logic [CRED_W-1:0] bin);
        logic [CRED_W-1:0] rem;
        logic [3:0]        tens;
        rem  = bin;
        tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end else begin
                rem  = rem;
            end
        end
        return {tens, rem[3:0]};
    endfunction

endpackage

// File: rtl/slot_tick_gen.sv
// Free-running divider producing a one-cycle reel step tick every
// TICK_DIV clock cycles; the tick is high while the counter sits at its
// last value.
module slot_tick_gen #(
    parameter int TICK_DIV = 2_500_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Divider counter: wraps to zero after reaching its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/slot_reel_controller.sv
// Three-reel slot machine sequencer: spins the reels, freezes them on
// stop presses, scores the result and keeps the credit balance. Reel codes
// and BCD credit digits feed the seven-segment decoders directly.
module slot_reel_controller
    import slot_pkg::*;
#(
    parameter int TICK_DIV   = 2_500_000,
    parameter int NUM_SYM    = 9,
    parameter int START_CRED = 10,
    parameter int MAX_CRED   = 99,
    parameter int BET        = 1,
    parameter int PAY3       = 10,
    parameter int PAY2       = 2,
    parameter int SHOW_TICKS = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic [3:0]        reel0,
    output logic [3:0]        reel1,
    output logic [3:0]        reel2,
    output logic [3:0]        cred_tens,
    output logic [3:0]        cred_ones,
    output logic [CRED_W-1:0] credits,
    output logic              spinning,
    output logic              win2,
    output logic              win3,
    output logic              game_over
);

    localparam logic [3:0]        NSYM    = 4'(NUM_SYM);
    localparam logic [CRED_W-1:0] START_C = CRED_W'(START_CRED);
    localparam logic [CRED_W-1:0] MAX_C   = CRED_W'(MAX_CRED);
    localparam logic [CRED_W-1:0] BET_C   = CRED_W'(BET);
    localparam logic [CRED_W-1:0] PAY3_C  = CRED_W'(PAY3);
    localparam logic [CRED_W-1:0] PAY2_C  = CRED_W'(PAY2);
    localparam logic              GO_RST  = (START_C < BET_C) ? 1'b1 : 1'b0;

    // Show counter runs 0..SHOW_TICKS-1; the tick at the last value ends SHOW.
    localparam int               SHOW_W    = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;
    localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_TICKS - 1);
    localparam logic [SHOW_W-1:0] SHOW_ONE  = SHOW_W'(1);

    state_t             state_r;
    state_t             state_nxt;
    logic [3:0]         reel0_r, reel1_r, reel2_r;
    logic [3:0]         reel0_nxt, reel1_nxt, reel2_nxt;
    logic [CRED_W-1:0]  credits_r, credits_nxt;
    logic               win2_r, win3_r, win2_nxt, win3_nxt;
    logic [SHOW_W-1:0]  show_cnt_r, show_cnt_nxt;
    logic               spinning_r, spinning_nxt;
    logic               game_over_r, game_over_nxt;

    logic               tick_s;
    logic               show_done_s;
    logic               can_bet_s;
    logic               match3_s, match2_s;
    logic [3:0]         step0_s, step1_s, step2_s;

    slot_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    assign step0_s     = reel_step(reel0_r, STRIDE0, NSYM);
    assign step1_s     = reel_step(reel1_r, STRIDE1, NSYM);
    assign step2_s     = reel_step(reel2_r, STRIDE2, NSYM);
    assign can_bet_s   = (credits_r >= BET_C);
    assign show_done_s = tick_s && (show_cnt_r == SHOW_LAST);
    assign match3_s    = (reel0_r == reel1_r) && (reel1_r == reel2_r);
    assign match2_s    = !match3_s && ((reel0_r == reel1_r) ||
                                       (reel1_r == reel2_r) ||
                                       (reel0_r == reel2_r));

    // State, reel, credit and flag registers; every visible output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            reel0_r     <= 4'd0;
            reel1_r     <= 4'd0;
            reel2_r     <= 4'd0;
            credits_r   <= START_C;
            win2_r      <= 1'b0;
            win3_r      <= 1'b0;
            show_cnt_r  <= '0;
            spinning_r  <= 1'b0;
            game_over_r <= GO_RST;
        end else begin
            state_r     <= state_nxt;
            reel0_r     <= reel0_nxt;
            reel1_r     <= reel1_nxt;
            reel2_r     <= reel2_nxt;
            credits_r   <= credits_nxt;
            win2_r      <= win2_nxt;
            win3_r      <= win3_nxt;
            show_cnt_r  <= show_cnt_nxt;
            spinning_r  <= spinning_nxt;
            game_over_r <= game_over_nxt;
        end
    end

    // Next-state logic: start only acts in IDLE, stop only in the spin states.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && can_bet_s) begin
                    state_nxt = ST_SPIN3;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SPIN3: begin
                if (stop) begin
                    state_nxt = ST_SPIN2;
                end else begin
                    state_nxt = ST_SPIN3;
                end
            end
            ST_SPIN2: begin
                if (stop) begin
                    state_nxt = ST_SPIN1;
                end else begin
                    state_nxt = ST_SPIN2;
                end
            end
            ST_SPIN1: begin
                if (stop) begin
                    state_nxt = ST_EVAL;
                end else begin
                    state_nxt = ST_SPIN1;
                end
            end
            ST_EVAL: begin
                state_nxt = ST_SHOW;
            end
            ST_SHOW: begin
                if (show_done_s) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_SHOW;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: reel stepping with freeze-on-stop, bet, payout, show timer.
    always_comb begin
        reel0_nxt    = reel0_r;
        reel1_nxt    = reel1_r;
        reel2_nxt    = reel2_r;
        credits_nxt  = credits_r;
        win2_nxt     = win2_r;
        win3_nxt     = win3_r;
        show_cnt_nxt = show_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start && can_bet_s) begin
                    credits_nxt = credits_r - BET_C;
                end else begin
                    credits_nxt = credits_r;
                end
            end
            ST_SPIN3: begin
                if (tick_s) begin
                    // A stop on the tick cycle keeps the pre-tick symbol.
                    reel0_nxt = stop ? reel0_r : step0_s;
                    reel1_nxt = step1_s;
                    reel2_nxt = step2_s;
                end else begin
                    reel0_nxt = reel0_r;
                end
            end
            ST_SPIN2: begin
                if (tick_s) begin
                    reel1_nxt = stop ? reel1_r : step1_s;
                    reel2_nxt = step2_s;
                end else begin
                    reel1_nxt = reel1_r;
                end
            end
            ST_SPIN1: begin
                if (tick_s) begin
                    reel2_nxt = stop ? reel2_r : step2_s;
                end else begin
                    reel2_nxt = reel2_r;
                end
            end
            ST_EVAL: begin
                win3_nxt     = match3_s;
                win2_nxt     = match2_s;
                show_cnt_nxt = '0;
                if (match3_s) begin
                    credits_nxt = cred_sat_add(credits_r, PAY3_C, MAX_C);
                end else if (match2_s) begin
                    credits_nxt = cred_sat_add(credits_r, PAY2_C, MAX_C);
                end else begin
                    credits_nxt = credits_r;
                end
            end
            ST_SHOW: begin
                if (show_done_s) begin
                    show_cnt_nxt = '0;
                    win2_nxt     = 1'b0;
                    win3_nxt     = 1'b0;
                end else if (tick_s) begin
                    show_cnt_nxt = show_cnt_r + SHOW_ONE;
                end else begin
                    show_cnt_nxt = show_cnt_r;
                end
            end
            default: begin
                credits_nxt = credits_r;
            end
        endcase
    end

    assign spinning_nxt  = (state_nxt == ST_SPIN3) || (state_nxt == ST_SPIN2) ||
                           (state_nxt == ST_SPIN1);
    assign game_over_nxt = (state_nxt == ST_IDLE) && (credits_nxt < BET_C);

    assign reel0     = reel0_r;
    assign reel1     = reel1_r;
    assign reel2     = reel2_r;
    assign credits   = credits_r;
    assign win2      = win2_r;
    assign win3      = win3_r;
    assign spinning  = spinning_r;
    assign game_over = game_over_r;
    assign {cred_tens, cred_ones} = bcd_split(credits_r);

endmodule

// File: tb/tb_slot_reel_controller.sv
// Directed bench for slot_reel_controller with a result scoreboard.
module tb_slot_reel_controller;

    logic       clk;
    logic       rst, start, stop;
    logic [3:0] reel0, reel1, reel2, cred_tens, cred_ones;
    logic [6:0] credits;
    logic       spinning, win2, win3, game_over;

    int tests  = 0;
    int fails  = 0;
    int cred_m = 0;
    int tb_cnt = 0;

    typedef struct {
        logic w2;
        logic w3;
        int   cred;
    } exp_t;
    exp_t sb[$];

    slot_reel_controller #(
        .TICK_DIV   (4),
        .SHOW_TICKS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .reel0     (reel0),
        .reel1     (reel1),
        .reel2     (reel2),
        .cred_tens (cred_tens),
        .cred_ones (cred_ones),
        .credits   (credits),
        .spinning  (spinning),
        .win2      (win2),
        .win3      (win3),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent tick-phase tracker: a tick lands on the edge after tb_cnt==3.
    always @(posedge clk) begin
        if (rst) tb_cnt <= 0;
        else if (tb_cnt == 3) tb_cnt <= 0;
        else tb_cnt <= tb_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int get_reel(input int which);
        case (which)
            0:       return {28'd0, reel0};
            1:       return {28'd0, reel1};
            default: return {28'd0, reel2};
        endcase
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_r0"}, {28'd0, reel0}, 0);
        check({tag, "_r1"}, {28'd0, reel1}, 0);
        check({tag, "_r2"}, {28'd0, reel2}, 0);
        check({tag, "_cred"}, {25'd0, credits}, 10);
        check({tag, "_tens"}, {28'd0, cred_tens}, 1);
        check({tag, "_ones"}, {28'd0, cred_ones}, 0);
        check({tag, "_spin"}, {31'd0, spinning}, 0);
        check({tag, "_w2"}, {31'd0, win2}, 0);
        check({tag, "_w3"}, {31'd0, win3}, 0);
        check({tag, "_gover"}, {31'd0, game_over}, 0);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_reel(input int which, input int target);
        int budget;
        budget = 200;
        while (get_reel(which) != target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("reel_reach", get_reel(which), target);
    endtask

    task automatic begin_game();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cred_m = cred_m - 1;
        check("spin_latency", {31'd0, spinning}, 1);
        check("bet_deduct", {25'd0, credits}, cred_m);
    endtask

    task automatic finish_game(input int t0, input int t1, input int t2, input bit probe);
        exp_t e;
        int   pay;
        wait_reel(0, t0);
        pulse_stop();
        check("freeze_r0", get_reel(0), t0);
        wait_reel(1, t1);
        pulse_stop();
        check("freeze_r1", get_reel(1), t1);
        wait_reel(2, t2);
        e.w3 = (t0 == t1) && (t1 == t2);
        e.w2 = !e.w3 && ((t0 == t1) || (t1 == t2) || (t0 == t2));
        pay  = e.w3 ? 10 : (e.w2 ? 2 : 0);
        e.cred = cred_m + pay;
        if (e.cred > 99) e.cred = 99;
        cred_m = e.cred;
        sb.push_back(e);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("eval_flags_low", {30'd0, win2, win3}, 0);
        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("win3", {31'd0, win3}, {31'd0, e.w3});
            check("win2", {31'd0, win2}, {31'd0, e.w2});
            check("pay_cred", {25'd0, credits}, e.cred);
            check("pay_tens", {28'd0, cred_tens}, e.cred / 10);
            check("pay_ones", {28'd0, cred_ones}, e.cred % 10);
        end
        check("hold_r0", get_reel(0), t0);
        check("hold_r1", get_reel(1), t1);
        check("hold_r2", get_reel(2), t2);
        if (probe) begin
            start = 1'b1;
            stop  = 1'b1;
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            @(negedge clk);
            check("show_start_ign", {25'd0, credits}, cred_m);
            check("show_no_spin", {31'd0, spinning}, 0);
            check("show_r2_hold", get_reel(2), t2);
        end
        repeat (12) @(negedge clk);
        check("idle_w2", {31'd0, win2}, 0);
        check("idle_w3", {31'd0, win3}, 0);
        check("idle_spin", {31'd0, spinning}, 0);
        check("idle_cred", {25'd0, credits}, cred_m);
        check("idle_gover", {31'd0, game_over}, (cred_m < 1) ? 1 : 0);
        check("idle_r0_hold", get_reel(0), t0);
    endtask

    task automatic play(input int t0, input int t1, input int t2);
        begin_game();
        finish_game(t0, t1, t2, 1'b0);
    endtask

    initial begin
        int nt;
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst    = 1'b0;
        cred_m = 10;

        // First spin: three ticks from 0/0/0.
        begin_game();
        nt = 0;
        for (int i = 0; i < 40 && nt < 3; i++) begin
            if (tb_cnt == 3) nt++;
            @(negedge clk);
        end
        check("tick_budget", nt, 3);
        check("t3_r0", {28'd0, reel0}, 3);
        check("t3_r1", {28'd0, reel1}, 6);
        check("t3_r2", {28'd0, reel2}, 3);
        check("t3_cred", {25'd0, credits}, 9);
        check("t3_spin", {31'd0, spinning}, 1);
        finish_game(5, 5, 5, 1'b0);

        // Pair with start/stop probe during SHOW, then a losing spin.
        begin_game();
        finish_game(5, 5, 2, 1'b1);
        play(0, 1, 2);

        // Climb to 91 with triples, then to 95 with pairs.
        for (int k = 0; k < 8; k++) play(k, k, k);
        play(1, 1, 3);
        play(2, 4, 2);
        play(7, 3, 3);
        play(0, 0, 8);
        check("preload95", {25'd0, credits}, 95);
        play(6, 6, 6);
        check("sat_cred", {25'd0, credits}, 99);
        check("sat_tens", {28'd0, cred_tens}, 9);
        check("sat_ones", {28'd0, cred_ones}, 9);
        play(4, 4, 4);

        // Drain to zero with losing spins.
        for (int g = 0; g < 120 && cred_m > 0; g++) play(0, 1, 2);
        check("drained", {25'd0, credits}, 0);
        check("gover_set", {31'd0, game_over}, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("gover_no_spin", {31'd0, spinning}, 0);
        check("gover_cred", {25'd0, credits}, 0);
        check("gover_hold", {31'd0, game_over}, 1);

        // Fresh reset, stop on a tick in SPIN3, then reset mid-SPIN2.
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        cred_m = 10;
        check_reset_vals("rst2");
        begin_game();
        nt = 0;
        for (int i = 0; i < 40 && nt < 2; i++) begin
            if (tb_cnt == 3) nt++;
            @(negedge clk);
        end
        check("tick_budget2", nt, 2);
        for (int i = 0; i < 10 && tb_cnt != 3; i++) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stoptick_r0", {28'd0, reel0}, 2);
        check("stoptick_r1", {28'd0, reel1}, 6);
        check("stoptick_r2", {28'd0, reel2}, 3);
        check("stoptick_spin", {31'd0, spinning}, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_spin2");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_spin", {31'd0, spinning}, 0);
        check("post_rst_cred", {25'd0, credits}, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
